// File: rtl/chunk_adder_if.sv
// Operand/result handshake bundle for chunk_adder.
// CHUNK_ADDER_OVF_EN adds the signed-overflow flag.
interface chunk_adder_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
`ifdef CHUNK_ADDER_OVF_EN
  logic             ovf;
  modport master (output in_valid, A, B, Cin, sub, out_ready,
                  input  in_ready, out_valid, S, Cout, ovf);
  modport slave  (input  in_valid, A, B, Cin, sub, out_ready,
                  output in_ready, out_valid, S, Cout, ovf);
`else
  modport master (output in_valid, A, B, Cin, sub, out_ready,
                  input  in_ready, out_valid, S, Cout);
  modport slave  (input  in_valid, A, B, Cin, sub, out_ready,
                  output in_ready, out_valid, S, Cout);
`endif
endinterface

// File: rtl/chunk_adder.sv
// Multi-cycle add/subtract, CHUNK bits per cycle LSB first, carry held between chunks.
// Optional signed-overflow output under CHUNK_ADDER_OVF_EN.
module chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  chunk_adder_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                         st;
  logic [KW-1:0]                  k;
  logic                           carry;
  logic [NCHUNK-1:0][CHUNK-1:0]   opa, opb, s_r;
  logic                           in_rdy, out_vld, cout_r;
  logic [CHUNK:0]                 csum;
  logic                           last;

  always_comb begin
    csum = {1'b0, opa[k]} + {1'b0, opb[k]} + {{CHUNK{1'b0}}, carry};
    last = (k == KW'(NCHUNK - 1));
  end

`ifdef CHUNK_ADDER_OVF_EN
  logic ovf_r;
  // On the last chunk, carry into the MSB is recovered from the MSB sum bit.
  logic c_into_msb;
  always_comb c_into_msb = csum[CHUNK-1] ^ opa[k][CHUNK-1] ^ opb[k][CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ovf_r <= 1'b0;
    else if (st == RUN && last)      ovf_r <= c_into_msb ^ csum[CHUNK];
  end
  assign bus.ovf = ovf_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      k       <= '0;
      carry   <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      s_r     <= '0;
      in_rdy  <= 1'b0;
      out_vld <= 1'b0;
      cout_r  <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          in_rdy <= 1'b1;
          if (bus.in_valid && in_rdy) begin
            opa    <= bus.A;
            // Subtract is A + ~B + !Cin, so invert B and the carry at capture.
            opb    <= bus.sub ? ~bus.B : bus.B;
            carry  <= bus.Cin ^ bus.sub;
            k      <= '0;
            in_rdy <= 1'b0;
            st     <= RUN;
          end
        end
        RUN: begin
          s_r[k] <= csum[CHUNK-1:0];
          carry  <= csum[CHUNK];
          if (last) begin
            cout_r  <= csum[CHUNK];
            out_vld <= 1'b1;
            st      <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            st      <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.S         = s_r;
  assign bus.Cout      = cout_r;
endmodule

// File: tb/tb_chunk_adder.sv
// Directed vector bench for chunk_adder: 32/8 instance plus an 8/8 single-chunk instance.
module tb_chunk_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chunk_adder_if #(.WIDTH(32)) bus ();
  chunk_adder_if #(.WIDTH(8))  bus8 ();

  chunk_adder #(.WIDTH(32), .CHUNK(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  chunk_adder #(.WIDTH(8),  .CHUNK(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] s;
    logic        cout, ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string name);
    int cnt;
    bus.A = v.a; bus.B = v.b; bus.Cin = v.cin; bus.sub = v.sub;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
    chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Disturb inputs after acceptance; result must not change.
    bus.in_valid = 1'b0;
    bus.A = ~v.a; bus.B = ~v.b; bus.Cin = ~v.cin; bus.sub = ~v.sub;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      @(posedge clk); cnt++; @(negedge clk);
    end
    chk({name, "_latency"}, 32'(cnt), 32'd4);
    chk({name, "_S"},    bus.S, v.s);
    chk({name, "_Cout"}, 32'(bus.Cout), 32'(v.cout));
`ifdef CHUNK_ADDER_OVF_EN
    chk({name, "_ovf"},  32'(bus.ovf), 32'(v.ovf));
`endif
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk({name, "_done_vld"}, 32'(bus.out_valid), 32'd0);
    chk({name, "_done_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[2] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[4] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[6] = '{32'h000000FF, 32'h00000001, 1'b1, 1'b0, 32'h00000101, 1'b0, 1'b0};

    bus.in_valid = 0; bus.A = 0; bus.B = 0; bus.Cin = 0; bus.sub = 0; bus.out_ready = 0;
    bus8.in_valid = 0; bus8.A = 0; bus8.B = 0; bus8.Cin = 0; bus8.sub = 0; bus8.out_ready = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_S",         bus.S, 32'd0);
    chk("rst_Cout",      32'(bus.Cout), 32'd0);
`ifdef CHUNK_ADDER_OVF_EN
    chk("rst_ovf",       32'(bus.ovf), 32'd0);
`endif
    rst_n = 1'b1;
    #1 chk("rel_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("rel_in_ready_high", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: DONE holds while new operands are offered.
    bus.A = 32'd1; bus.B = 32'd2; bus.Cin = 0; bus.sub = 0; bus.in_valid = 1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    bus.A = 32'h100; bus.B = 32'h100; bus.Cin = 1; bus.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_vld%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_hold_S%0d", i),   bus.S, 32'd3);
      chk($sformatf("bp_hold_rdy%0d", i), 32'(bus.in_ready), 32'd0);
    end
    chk("bp_Cout", 32'(bus.Cout), 32'd0);
    bus.in_valid = 0; bus.out_ready = 1;
    @(negedge clk);
    bus.out_ready = 0;
    chk("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
    chk("bp_rel_vld", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("bp_no_capture", 32'(bus.in_ready), 32'd1);

    // Reset two cycles into RUN
    bus.A = 32'hAAAAAAAA; bus.B = 32'h55555555; bus.in_valid = 1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(bus.out_valid), 32'd0);
    chk("midrst_S",   bus.S, 32'd0);
    chk("midrst_rdy", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vecs[4], "post_rst");

    // Single-chunk instance
    @(negedge clk);
    bus8.A = 8'h80; bus8.B = 8'h80; bus8.Cin = 1; bus8.sub = 0; bus8.in_valid = 1;
    for (int i = 0; i < 20 && !bus8.in_ready; i++) @(negedge clk);
    chk("w8_in_ready", 32'(bus8.in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    bus8.in_valid = 0;
    chk("w8_vld_edge0", 32'(bus8.out_valid), 32'd0);
    @(negedge clk);
    chk("w8_vld_edge1", 32'(bus8.out_valid), 32'd1);
    chk("w8_S",    32'(bus8.S), 32'h01);
    chk("w8_Cout", 32'(bus8.Cout), 32'd1);
`ifdef CHUNK_ADDER_OVF_EN
    chk("w8_ovf",  32'(bus8.ovf), 32'd1);
`endif
    bus8.out_ready = 1;
    @(negedge clk);
    chk("w8_done", 32'(bus8.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
